snow64_lar_file_mem_access_controller: RTL and testbench

// Sequences the LAR file's memory traffic onto a single memory bus port.

---
 rtl/snow64_lar_file_mem_access_controller.sv | 142 ++++++++++++++
 tb/tb_snow64_lar_file_mem_access_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_lar_file_mem_access_controller.sv
// Serialises LAR file write-back and fill requests onto one req/ack memory bus port.
// Write-back always precedes fill when both are sampled together; a one-cycle cooldown follows every op.
module snow64_lar_file_mem_access_controller #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 64,
  localparam int OFFS_WIDTH = $clog2(DATA_WIDTH / 8),
  localparam int BASE_WIDTH = ADDR_WIDTH - OFFS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_mem_read_req,
  input  logic [BASE_WIDTH-1:0] in_mem_read_base_addr,
  input  logic                  in_mem_write_req,
  input  logic [BASE_WIDTH-1:0] in_mem_write_base_addr,
  input  logic [DATA_WIDTH-1:0] in_mem_write_data,
  output logic                  out_mem_read_valid,
  output logic [DATA_WIDTH-1:0] out_mem_read_data,
  output logic                  out_mem_write_valid,
  output logic                  out_bus_req,
  output logic                  out_bus_we,
  output logic [ADDR_WIDTH-1:0] out_bus_addr,
  output logic [DATA_WIDTH-1:0] out_bus_wdata,
  input  logic                  in_bus_ack,
  input  logic [DATA_WIDTH-1:0] in_bus_rdata,
  output logic                  out_busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_READ     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    pend_rd_q;
  logic [BASE_WIDTH-1:0]   pend_rd_base_q;
  logic                    bus_req_q;
  logic                    bus_we_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    wr_valid_q;
  logic                    busy_q;

  // Request sequencing FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pend_rd_q      <= 1'b0;
      pend_rd_base_q <= '0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      wr_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_mem_write_req) begin
            state_q        <= ST_WRITE;
            busy_q         <= 1'b1;
            bus_req_q      <= 1'b1;
            bus_we_q       <= 1'b1;
            bus_addr_q     <= {in_mem_write_base_addr, {OFFS_WIDTH{1'b0}}};
            bus_wdata_q    <= in_mem_write_data;
            pend_rd_q      <= in_mem_read_req;
            pend_rd_base_q <= in_mem_read_base_addr;
          end else if (in_mem_read_req) begin
            state_q        <= ST_READ;
            busy_q         <= 1'b1;
            bus_req_q      <= 1'b1;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= {in_mem_read_base_addr, {OFFS_WIDTH{1'b0}}};
            bus_wdata_q    <= '0;
            pend_rd_q      <= 1'b0;
            pend_rd_base_q <= in_mem_read_base_addr;
          end else begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (in_bus_ack && bus_req_q) begin
            wr_valid_q <= 1'b1;
            // A fill sampled with this write-back starts without a bus bubble.
            if (pend_rd_q) begin
              state_q     <= ST_READ;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= {pend_rd_base_q, {OFFS_WIDTH{1'b0}}};
              bus_wdata_q <= '0;
              pend_rd_q   <= 1'b0;
            end else begin
              state_q   <= ST_COOLDOWN;
              bus_req_q <= 1'b0;
            end
          end else begin
            state_q <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (in_bus_ack && bus_req_q) begin
            state_q    <= ST_COOLDOWN;
            bus_req_q  <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= in_bus_rdata;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_COOLDOWN: begin
          // Requests are still high this cycle and must not be re-sampled.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          bus_req_q <= 1'b0;
          pend_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_mem_read_valid  = rd_valid_q;
  assign out_mem_read_data   = rd_data_q;
  assign out_mem_write_valid = wr_valid_q;
  assign out_bus_req         = bus_req_q;
  assign out_bus_we          = bus_we_q;
  assign out_bus_addr        = bus_addr_q;
  assign out_bus_wdata       = bus_wdata_q;
  assign out_busy            = busy_q;

endmodule

// File: tb/tb_snow64_lar_file_mem_access_controller.sv
// Bench: plays LAR file and memory, checks bus transactions and valid pulses against a transaction-level model.
module tb_snow64_lar_file_mem_access_controller;

  logic         clk;
  logic         rst_n;
  logic         in_mem_read_req;
  logic [58:0]  in_mem_read_base_addr;
  logic         in_mem_write_req;
  logic [58:0]  in_mem_write_base_addr;
  logic [255:0] in_mem_write_data;
  logic         out_mem_read_valid;
  logic [255:0] out_mem_read_data;
  logic         out_mem_write_valid;
  logic         out_bus_req;
  logic         out_bus_we;
  logic [63:0]  out_bus_addr;
  logic [255:0] out_bus_wdata;
  logic         in_bus_ack;
  logic [255:0] in_bus_rdata;
  logic         out_busy;

  snow64_lar_file_mem_access_controller dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_mem_read_req        (in_mem_read_req),
    .in_mem_read_base_addr  (in_mem_read_base_addr),
    .in_mem_write_req       (in_mem_write_req),
    .in_mem_write_base_addr (in_mem_write_base_addr),
    .in_mem_write_data      (in_mem_write_data),
    .out_mem_read_valid     (out_mem_read_valid),
    .out_mem_read_data      (out_mem_read_data),
    .out_mem_write_valid    (out_mem_write_valid),
    .out_bus_req            (out_bus_req),
    .out_bus_we             (out_bus_we),
    .out_bus_addr           (out_bus_addr),
    .out_bus_wdata          (out_bus_wdata),
    .in_bus_ack             (in_bus_ack),
    .in_bus_rdata           (in_bus_rdata),
    .out_busy               (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         do_wr;
    logic         do_rd;
    logic         late_rd;
    logic [58:0]  wr_base;
    logic [58:0]  rd_base;
    logic [255:0] wr_data;
    logic [255:0] rdata;
    int           dly0;
    int           dly1;
    int           exp_ntx;
    logic         exp_we0;
    logic [63:0]  exp_addr0;
    int           exp_wv;
    int           exp_rv;
  } vec_t;

  int           n_chk  = 0;
  int           n_pass = 0;
  logic [255:0] last_fill = '0;
  vec_t         tbl[6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic vec_t mkv(input logic w, input logic r, input logic late,
                               input logic [58:0] wb, input logic [58:0] rb,
                               input logic [255:0] wd, input logic [255:0] rd,
                               input int d0, input int d1, input int ntx,
                               input logic we0, input logic [63:0] a0, input int wv, input int rv);
    vec_t v;
    v.do_wr = w; v.do_rd = r; v.late_rd = late; v.wr_base = wb; v.rd_base = rb;
    v.wr_data = wd; v.rdata = rd; v.dly0 = d0; v.dly1 = d1; v.exp_ntx = ntx;
    v.exp_we0 = we0; v.exp_addr0 = a0; v.exp_wv = wv; v.exp_rv = rv;
    return v;
  endfunction

  // One LAR-file operation from the requester's point of view; starts and ends #1 after a rising edge.
  task automatic run_op(input string nm, input vec_t v);
    int cyc = 0, cnt = 0, ntx = 0, wv_n = 0, rv_n = 0, tail = 0, stab_err = 0, ne = 0, d;
    int wv_cyc = -1, rv_cyc = -1, ack_cyc = -10;
    logic in_tx = 1'b0, drop_wr = 1'b0, drop_rd = 1'b0, rd_raised;
    logic h_we; logic [63:0] h_addr; logic [255:0] h_wd;
    logic t_we[4]; logic [63:0] t_addr[4]; logic [255:0] t_wd[4];
    logic e_we[2]; logic [63:0] e_addr[2]; logic [255:0] e_wd[2];
    in_mem_write_req       = v.do_wr;
    in_mem_write_base_addr = v.wr_base;
    in_mem_write_data      = v.wr_data;
    in_mem_read_req        = v.do_rd && !v.late_rd;
    in_mem_read_base_addr  = v.rd_base;
    rd_raised              = in_mem_read_req;
    while (tail < 4 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (drop_wr) begin in_mem_write_req = 1'b0; drop_wr = 1'b0; end
      if (drop_rd) begin in_mem_read_req = 1'b0; drop_rd = 1'b0; end
      if (out_mem_write_valid) begin
        wv_n++; wv_cyc = cyc; drop_wr = 1'b1;
        chki({nm, " wv_after_ack"}, cyc, ack_cyc + 1);
        chki({nm, " b2b_read"}, int'(out_bus_req && !out_bus_we), int'(v.do_rd && !v.late_rd));
      end
      if (out_mem_read_valid) begin
        rv_n++; rv_cyc = cyc; drop_rd = 1'b1;
        chki({nm, " rv_after_ack"}, cyc, ack_cyc + 1);
        chk({nm, " rdata"}, out_mem_read_data, v.rdata);
      end
      if (v.late_rd && !rd_raised && out_bus_req && out_bus_we) begin
        in_mem_read_req = 1'b1; rd_raised = 1'b1;
      end
      in_bus_ack = 1'b0;
      if (out_bus_req) begin
        if (!in_tx) begin
          in_tx = 1'b1; cnt = 0; h_we = out_bus_we; h_addr = out_bus_addr; h_wd = out_bus_wdata;
        end else if (out_bus_we !== h_we || out_bus_addr !== h_addr || out_bus_wdata !== h_wd) begin
          stab_err++;
        end
        d = (ntx == 0) ? v.dly0 : v.dly1;
        if (cnt >= d) begin
          in_bus_ack = 1'b1; in_bus_rdata = v.rdata;
          if (ntx < 4) begin t_we[ntx] = h_we; t_addr[ntx] = h_addr; t_wd[ntx] = h_wd; end
          ntx++; ack_cyc = cyc; in_tx = 1'b0;
        end else begin
          cnt++;
        end
      end else begin
        in_tx = 1'b0;
        in_bus_ack = ($urandom_range(0, 3) == 0);
        in_bus_rdata = rand_data();
      end
      if ((!v.do_wr || wv_n > 0) && (!v.do_rd || rv_n > 0)) tail++;
    end
    in_bus_ack = 1'b0; in_mem_write_req = 1'b0; in_mem_read_req = 1'b0;
    chki({nm, " no_timeout"}, int'(cyc < 200), 1);
    // Reference: write-back line first (if any), then the fill line.
    if (v.do_wr) begin e_we[ne] = 1'b1; e_addr[ne] = {v.wr_base, 5'd0}; e_wd[ne] = v.wr_data; ne++; end
    if (v.do_rd) begin e_we[ne] = 1'b0; e_addr[ne] = {v.rd_base, 5'd0}; e_wd[ne] = '0; ne++; end
    chki({nm, " ntx_model"}, ntx, ne);
    chki({nm, " ntx_table"}, ntx, v.exp_ntx);
    for (int i = 0; i < ne && i < ntx; i++) begin
      chki({nm, " tx_we"}, int'(t_we[i]), int'(e_we[i]));
      chk({nm, " tx_addr"}, 256'(t_addr[i]), 256'(e_addr[i]));
      chk({nm, " tx_wdata"}, t_wd[i], e_wd[i]);
    end
    if (ntx > 0) begin
      chki({nm, " we0_table"}, int'(t_we[0]), int'(v.exp_we0));
      chk({nm, " addr0_table"}, 256'(t_addr[0]), 256'(v.exp_addr0));
    end
    chki({nm, " wv_count"}, wv_n, v.exp_wv);
    chki({nm, " rv_count"}, rv_n, v.exp_rv);
    chki({nm, " bus_stable"}, stab_err, 0);
    if (!v.late_rd) begin
      if (v.do_wr) chki({nm, " wr_latency"}, wv_cyc, 2 + v.dly0);
      if (v.do_rd) chki({nm, " rd_latency"}, rv_cyc, v.do_wr ? 3 + v.dly0 + v.dly1 : 2 + v.dly0);
    end
    if (v.do_wr && v.do_rd) chki({nm, " wr_before_rd"}, int'(wv_cyc < rv_cyc), 1);
    if (v.do_rd) last_fill = v.rdata;
    chk({nm, " rdata_hold"}, out_mem_read_data, last_fill);
    chki({nm, " idle_at_end"}, int'(out_busy || out_bus_req), 0);
  endtask

  initial begin
    vec_t v;
    logic [63:0] r64;
    int bad;
    rst_n = 1'b0; in_mem_read_req = 1'b0; in_mem_write_req = 1'b0; in_bus_ack = 1'b0;
    in_mem_read_base_addr = '0; in_mem_write_base_addr = '0; in_mem_write_data = '0; in_bus_rdata = '0;
    #2;
    chki("reset_outs", int'(out_bus_req || out_busy || out_mem_read_valid || out_mem_write_valid || out_bus_we), 0);
    chk("reset_addr", 256'(out_bus_addr), 256'd0);
    chk("reset_rdata", out_mem_read_data, 256'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Spurious acks while idle must do nothing.
    bad = 0;
    in_bus_ack = 1'b1; in_bus_rdata = {8{32'hDEADBEEF}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_bus_req || out_busy || out_mem_read_valid || out_mem_write_valid) bad++;
    end
    in_bus_ack = 1'b0;
    chki("spurious_ack_idle", bad, 0);

    tbl[0] = mkv(1'b0, 1'b1, 1'b0, 59'h0, 59'h10, 256'h0, {8{32'hA5A5A5A5}}, 3, 0, 1, 1'b0, 64'h200, 0, 1);
    tbl[1] = mkv(1'b1, 1'b0, 1'b0, 59'h3, 59'h0, 256'h1234, 256'h0, 1, 0, 1, 1'b1, 64'h60, 1, 0);
    tbl[2] = mkv(1'b1, 1'b1, 1'b0, 59'h7, 59'h9, 256'hCAFE, 256'hBEEF, 2, 1, 2, 1'b1, 64'hE0, 1, 1);
    tbl[3] = mkv(1'b0, 1'b1, 1'b0, 59'h0, 59'h20, 256'h0, 256'h11, 0, 0, 1, 1'b0, 64'h400, 0, 1);
    tbl[4] = mkv(1'b0, 1'b1, 1'b0, 59'h0, 59'h21, 256'h0, 256'h22, 0, 0, 1, 1'b0, 64'h420, 0, 1);
    tbl[5] = mkv(1'b1, 1'b1, 1'b1, 59'h5, 59'h6, 256'h55, 256'h66, 1, 0, 2, 1'b1, 64'hA0, 1, 1);
    for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // Randomised operations; expectations follow from the ordering rules alone.
    for (int i = 0; i < 40; i++) begin
      v.do_wr = $urandom_range(0, 1);
      v.do_rd = v.do_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.late_rd = v.do_wr && v.do_rd && ($urandom_range(0, 3) == 0);
      r64 = {$urandom(), $urandom()}; v.wr_base = r64[58:0];
      r64 = {$urandom(), $urandom()}; v.rd_base = r64[58:0];
      v.wr_data = rand_data(); v.rdata = rand_data();
      v.dly0 = $urandom_range(0, 4); v.dly1 = $urandom_range(0, 4);
      v.exp_ntx = int'(v.do_wr) + int'(v.do_rd);
      v.exp_we0 = v.do_wr;
      v.exp_addr0 = v.do_wr ? {v.wr_base, 5'd0} : {v.rd_base, 5'd0};
      v.exp_wv = int'(v.do_wr); v.exp_rv = int'(v.do_rd);
      run_op($sformatf("rnd%0d", i), v);
    end

    // Asynchronous reset in the middle of a fill.
    in_mem_read_req = 1'b1; in_mem_read_base_addr = 59'h30; in_bus_ack = 1'b0;
    for (int i = 0; i < 10 && !out_bus_req; i++) begin @(posedge clk); #1; end
    chki("rst_reach_read", int'(out_bus_req && out_busy && !out_bus_we), 1);
    #3 rst_n = 1'b0;
    #1;
    chki("rst_async_drop", int'(out_bus_req || out_busy || out_mem_read_valid || out_mem_write_valid), 0);
    chk("rst_rdata_clear", out_mem_read_data, 256'd0);
    last_fill = '0;
    @(posedge clk); #1; in_mem_read_req = 1'b0; rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_bus_req || out_busy || out_mem_read_valid || out_mem_write_valid) bad++;
    end
    chki("post_rst_quiet", bad, 0);
    run_op("after_rst", mkv(1'b1, 1'b1, 1'b0, 59'h11, 59'h12, 256'h77, 256'h88, 0, 0, 2, 1'b1, 64'h220, 1, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
